// File: rtl/toggle_link_pkg.sv
// Shared constants for the two-phase toggle event link, so the sender-side wrapper
// and the receiver agree on defaults and legal parameter ranges.
package toggle_link_pkg;

  localparam int unsigned TOG_SYNC_STAGES_DEF = 2;
  localparam int unsigned TOG_CNT_WIDTH_DEF   = 3;

  localparam int unsigned TOG_SYNC_STAGES_MIN = 2;
  localparam int unsigned TOG_SYNC_STAGES_MAX = 4;
  localparam int unsigned TOG_CNT_WIDTH_MIN   = 1;
  localparam int unsigned TOG_CNT_WIDTH_MAX   = 16;

  function automatic bit tog_params_legal(int unsigned sync_stages, int unsigned cnt_width);
    return (sync_stages >= TOG_SYNC_STAGES_MIN) && (sync_stages <= TOG_SYNC_STAGES_MAX) &&
           (cnt_width >= TOG_CNT_WIDTH_MIN) && (cnt_width <= TOG_CNT_WIDTH_MAX);
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer for a single asynchronous bit; reused by the debouncer input.
module sync_chain
  import toggle_link_pkg::*;
#(
  parameter int unsigned DEPTH = TOG_SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic RSTN,
  input  logic d_i,
  output logic q_o
);

  logic [DEPTH-1:0] s_q;

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      s_q <= '0;
    end else begin
      s_q <= {s_q[DEPTH-2:0], d_i};
    end
  end

  assign q_o = s_q[DEPTH-1];

endmodule

// File: rtl/toggle_pulse_receiver.sv
// Receiver for a two-phase toggle link: synchronizes the toggle, emits one pulse per
// transition, counts events and returns a toggle acknowledge to the sender.
module toggle_pulse_receiver
  import toggle_link_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = TOG_SYNC_STAGES_DEF,
  parameter int unsigned CNT_WIDTH   = TOG_CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 RSTN,
  input  logic                 tog_in,
  input  logic                 clr,
  output logic                 pulse,
  output logic                 ack_tog,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 overflow
);

  logic                 sync;
  logic                 evt;
  logic                 prev_q;
  logic                 pulse_q, pulse_d;
  logic                 ack_q, ack_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 ovf_q, ovf_d;

  sync_chain #(
    .DEPTH (SYNC_STAGES)
  ) u_sync_chain (
    .clk  (clk),
    .RSTN (RSTN),
    .d_i  (tog_in),
    .q_o  (sync)
  );

  assign evt = sync ^ prev_q;

  always_comb begin
    pulse_d = evt;
    ack_d   = ack_q ^ evt;
    count_d = count_q;
    ovf_d   = ovf_q;
    // Clear wins over a coincident wrap, but the colliding event itself still counts.
    if (clr) begin
      count_d = CNT_WIDTH'(evt);
      ovf_d   = 1'b0;
    end else if (evt) begin
      count_d = count_q + CNT_WIDTH'(1);
      ovf_d   = ovf_q | (&count_q);
    end
  end

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
      ack_q   <= 1'b0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      prev_q  <= sync;
      pulse_q <= pulse_d;
      ack_q   <= ack_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign pulse    = pulse_q;
  assign ack_tog  = ack_q;
  assign count    = count_q;
  assign overflow = ovf_q;

endmodule
